// File: rtl/decode_stage.sv
// RV32I/M instruction-decode stage: combinational decode of the incoming word into an
// elastic one-entry pipeline register with valid/ready handshakes on both sides.
module decode_stage #(
    parameter int XLEN            = 32,
    parameter bit ENABLE_M        = 1'b1,
    parameter bit ZERO_RD_NOWRITE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [2:0]      out_aluop,
    output logic [15:0]     out_ctrl,
    output logic [XLEN-1:0] out_imm
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic        is_load, is_store, is_opimm, is_op;
    logic        known_op, illegal, regwrite_raw;
    logic [31:0] imm32;
    logic [4:0]  d_rs1;
    logic [2:0]  d_aluop;
    logic [15:0] d_ctrl;
    logic [XLEN-1:0] d_imm;
    logic        xfer;

    assign in_ready = ~out_valid | out_ready;
    assign xfer     = in_valid & in_ready;

    always_comb begin
        opcode    = in_instr[6:0];
        funct3    = in_instr[14:12];
        funct7    = in_instr[31:25];
        rd        = in_instr[11:7];

        is_lui    = (opcode == OPC_LUI);
        is_auipc  = (opcode == OPC_AUIPC);
        is_jal    = (opcode == OPC_JAL);
        is_jalr   = (opcode == OPC_JALR);
        is_branch = (opcode == OPC_BRANCH);
        is_load   = (opcode == OPC_LOAD);
        is_store  = (opcode == OPC_STORE);
        is_opimm  = (opcode == OPC_OPIMM);
        is_op     = (opcode == OPC_OP);
        known_op  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                    is_load | is_store | is_opimm | is_op;

        illegal = ~known_op | (in_instr[1:0] != 2'b11);
        if (is_op && !(funct7 == F7_BASE || funct7 == F7_ALT || (ENABLE_M && funct7 == F7_MUL)))
            illegal = 1'b1;
        if (is_op && funct7 == F7_ALT && !(funct3 == 3'b000 || funct3 == 3'b101))
            illegal = 1'b1;
        if (is_opimm && funct3 == 3'b001 && funct7 != F7_BASE)
            illegal = 1'b1;
        if (is_opimm && funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
            illegal = 1'b1;
        if (is_load && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
            illegal = 1'b1;
        if (is_store && funct3 > 3'b010)
            illegal = 1'b1;
        if (is_branch && funct3[2:1] == 2'b01)
            illegal = 1'b1;
        if (is_jalr && funct3 != 3'b000)
            illegal = 1'b1;

        regwrite_raw = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op;
        if (ZERO_RD_NOWRITE && rd == 5'd0)
            regwrite_raw = 1'b0;

        // Side-effecting flags are suppressed on illegal so execute only sees a trap request.
        d_ctrl     = '0;
        d_ctrl[0]  = ~(is_lui | is_auipc | is_jal);
        d_ctrl[1]  = is_branch | is_store | is_op;
        d_ctrl[2]  = is_load & ~illegal;
        d_ctrl[3]  = is_store & ~illegal;
        d_ctrl[4]  = regwrite_raw & ~illegal;
        d_ctrl[5]  = (is_jal | is_jalr) & ~illegal;
        d_ctrl[6]  = is_jalr;
        d_ctrl[7]  = is_branch & ~illegal;
        d_ctrl[8]  = is_op & (funct7 == F7_ALT);
        d_ctrl[9]  = (funct7 == F7_ALT);
        d_ctrl[10] = (funct3 == 3'b001);
        d_ctrl[11] = is_auipc | is_jal | is_jalr;
        d_ctrl[12] = ~(is_op | is_branch);
        d_ctrl[13] = is_op & (funct7 == F7_MUL) & ENABLE_M;
        d_ctrl[14] = illegal;

        d_rs1   = is_lui ? 5'd0 : in_instr[19:15];
        d_aluop = (is_op | is_opimm) ? funct3 : 3'b000;

        if (is_jal)
            imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
        else if (is_branch)
            imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
        else if (is_store)
            imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (is_load || is_opimm || is_jalr)
            imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        else
            imm32 = {in_instr[31:12], 12'b0};
        d_imm = XLEN'($signed(imm32));
    end

    // Flush outranks a transfer and also blocks the data load, so a killed word never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_rs1    <= '0;
            out_rs2    <= '0;
            out_rd     <= '0;
            out_funct3 <= '0;
            out_aluop  <= '0;
            out_ctrl   <= '0;
            out_imm    <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (xfer)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;

            if (xfer && !flush) begin
                out_pc     <= in_pc;
                out_rs1    <= d_rs1;
                out_rs2    <= in_instr[24:20];
                out_rd     <= rd;
                out_funct3 <= funct3;
                out_aluop  <= d_aluop;
                out_ctrl   <= d_ctrl;
                out_imm    <= d_imm;
            end
        end
    end

endmodule
